branch_eval: RTL and testbench

BRANCH_EVAL -- requirements
Module: branch_eval

---
 rtl/branch_eval.sv | 183 ++++++++++++++++++
 tb/tb_branch_eval.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_eval.sv
// Branch condition evaluator for x86 Jcc / LOOPcc / JCXZ opcodes.
// Three-state request pipeline with registered results and saturating statistics.
module branch_eval #(
  parameter int COUNT_WIDTH = 16,
  parameter bit ALIAS_6X    = 1'b1,
  parameter int STATS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             opcode,
  input  logic [15:0]            flags,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   stats_clear,
  output logic                   busy,
  output logic                   valid,
  output logic                   taken,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_we,
  output logic [STATS_WIDTH-1:0] eval_count,
  output logic [STATS_WIDTH-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_OF = 11;

  state_e                 state_q;
  logic [7:0]             op_q;
  logic [15:0]            flags_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  logic                   valid_q, taken_q, illegal_q, count_we_q;
  logic [COUNT_WIDTH-1:0] count_out_q;
  logic [STATS_WIDTH-1:0] eval_count_q, eval_count_d;
  logic [STATS_WIDTH-1:0] taken_count_q, taken_count_d;

  logic                   taken_d, illegal_d, count_we_d;
  logic [COUNT_WIDTH-1:0] count_out_d;

  // Even condition codes test a predicate; the odd neighbour is its inverse.
  function automatic logic cc_met(input logic [3:0] cc, input logic [15:0] f);
    logic base;
    unique case (cc[3:1])
      3'd0:    base = f[FLAG_OF];
      3'd1:    base = f[FLAG_CF];
      3'd2:    base = f[FLAG_ZF];
      3'd3:    base = f[FLAG_CF] | f[FLAG_ZF];
      3'd4:    base = f[FLAG_SF];
      3'd5:    base = f[FLAG_PF];
      3'd6:    base = f[FLAG_SF] ^ f[FLAG_OF];
      default: base = (f[FLAG_SF] ^ f[FLAG_OF]) | f[FLAG_ZF];
    endcase
    return base ^ cc[0];
  endfunction

  logic                   is_jcc;
  logic [COUNT_WIDTH-1:0] cnt_dec;
  logic                   dec_nonzero;

  assign is_jcc      = (op_q[7:4] == 4'h7) || (ALIAS_6X && (op_q[7:4] == 4'h6));
  assign cnt_dec     = cnt_q - COUNT_WIDTH'(1);
  assign dec_nonzero = (cnt_dec != '0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    taken_d     = 1'b0;
    illegal_d   = 1'b0;
    count_we_d  = 1'b0;
    count_out_d = cnt_q;
    if (is_jcc) begin
      taken_d = cc_met(op_q[3:0], flags_q);
    end else begin
      unique case (op_q)
        8'hE0: begin
          count_out_d = cnt_dec;
          count_we_d  = 1'b1;
          taken_d     = dec_nonzero & ~flags_q[FLAG_ZF];
        end
        8'hE1: begin
          count_out_d = cnt_dec;
          count_we_d  = 1'b1;
          taken_d     = dec_nonzero & flags_q[FLAG_ZF];
        end
        8'hE2: begin
          count_out_d = cnt_dec;
          count_we_d  = 1'b1;
          taken_d     = dec_nonzero;
        end
        8'hE3: begin
          taken_d = (cnt_q == '0);
        end
        default: begin
          illegal_d = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      count_we_q  <= 1'b0;
      count_out_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          valid_q    <= 1'b0;
          count_we_q <= 1'b0;
          if (start) begin
            op_q    <= opcode;
            flags_q <= flags;
            cnt_q   <= count_in;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          valid_q     <= 1'b1;
          taken_q     <= taken_d;
          illegal_q   <= illegal_d;
          count_we_q  <= count_we_d;
          count_out_q <= count_out_d;
          state_q     <= S_DONE;
        end
        default: begin
          valid_q    <= 1'b0;
          count_we_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Counters advance on the edge that closes the valid cycle, so a clear
  // raised during that cycle naturally wins over the increment.
  always_comb begin
    eval_count_d  = eval_count_q;
    taken_count_d = taken_count_q;
    if (stats_clear) begin
      eval_count_d  = '0;
      taken_count_d = '0;
    end else if (valid_q) begin
      if (eval_count_q != '1) eval_count_d = eval_count_q + STATS_WIDTH'(1);
      if (taken_q && (taken_count_q != '1)) taken_count_d = taken_count_q + STATS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eval_count_q  <= '0;
      taken_count_q <= '0;
    end else begin
      eval_count_q  <= eval_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign valid       = valid_q;
  assign taken       = taken_q;
  assign illegal     = illegal_q;
  assign count_out   = count_out_q;
  assign count_we    = count_we_q;
  assign eval_count  = eval_count_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_eval.sv
// Bench for branch_eval: two instances (default, and ALIAS_6X=0 with 2-bit stats)
// driven in parallel and compared with a flag-level reference model.
module tb_branch_eval;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stats_clear = 1'b0;
  logic [7:0]    opcode = '0;
  logic [15:0]   flags = '0;
  logic [CW-1:0] count_in = '0;

  logic          a_busy, a_valid, a_taken, a_illegal, a_count_we;
  logic [CW-1:0] a_count_out;
  logic [15:0]   a_eval_count, a_taken_count;
  logic          b_busy, b_valid, b_taken, b_illegal, b_count_we;
  logic [CW-1:0] b_count_out;
  logic [1:0]    b_eval_count, b_taken_count;

  branch_eval #(.COUNT_WIDTH(CW), .ALIAS_6X(1'b1), .STATS_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .flags(flags),
    .count_in(count_in), .stats_clear(stats_clear), .busy(a_busy), .valid(a_valid),
    .taken(a_taken), .illegal(a_illegal), .count_out(a_count_out), .count_we(a_count_we),
    .eval_count(a_eval_count), .taken_count(a_taken_count)
  );

  branch_eval #(.COUNT_WIDTH(CW), .ALIAS_6X(1'b0), .STATS_WIDTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .flags(flags),
    .count_in(count_in), .stats_clear(stats_clear), .busy(b_busy), .valid(b_valid),
    .taken(b_taken), .illegal(b_illegal), .count_out(b_count_out), .count_we(b_count_we),
    .eval_count(b_eval_count), .taken_count(b_taken_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic        we;
    logic [15:0] cnt;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_eval_a = 0, exp_taken_a = 0, exp_eval_b = 0, exp_taken_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] op, input logic [15:0] f,
                                 input logic [15:0] c, input bit alias6);
    res_t r;
    bit cf, pf, zf, sf, of;
    int nc;
    cf = f[0]; pf = f[2]; zf = f[6]; sf = f[7]; of = f[11];
    r.taken = 1'b0; r.illegal = 1'b0; r.we = 1'b0; r.cnt = c;
    if ((op >= 8'h70 && op <= 8'h7F) || (alias6 && op >= 8'h60 && op <= 8'h6F)) begin
      case (op % 16)
        0:  r.taken = of;
        1:  r.taken = !of;
        2:  r.taken = cf;
        3:  r.taken = !cf;
        4:  r.taken = zf;
        5:  r.taken = !zf;
        6:  r.taken = cf || zf;
        7:  r.taken = !(cf || zf);
        8:  r.taken = sf;
        9:  r.taken = !sf;
        10: r.taken = pf;
        11: r.taken = !pf;
        12: r.taken = sf != of;
        13: r.taken = sf == of;
        14: r.taken = (sf != of) || zf;
        default: r.taken = !((sf != of) || zf);
      endcase
    end else if (op == 8'hE0 || op == 8'hE1 || op == 8'hE2) begin
      nc = (int'(c) + 65535) % 65536;
      r.cnt = 16'(nc);
      r.we  = 1'b1;
      if (op == 8'hE2)      r.taken = (nc != 0);
      else if (op == 8'hE1) r.taken = (nc != 0) && zf;
      else                  r.taken = (nc != 0) && !zf;
    end else if (op == 8'hE3) begin
      r.taken = (c == 16'd0);
    end else begin
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  function automatic int sat_inc(input int x, input int max);
    return (x < max) ? x + 1 : max;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_a_eval"},  32'(a_eval_count),  32'(exp_eval_a));
    check({tag, "_a_taken"}, 32'(a_taken_count), 32'(exp_taken_a));
    check({tag, "_b_eval"},  32'(b_eval_count),  32'(exp_eval_b));
    check({tag, "_b_taken"}, 32'(b_taken_count), 32'(exp_taken_b));
  endtask

  // One request: accept, scramble inputs, check latency, results, hold and stats.
  task automatic do_req(input logic [7:0] op, input logic [15:0] fl,
                        input logic [15:0] cnt, input bit clr);
    res_t ea, eb;
    int   k;
    ea = model(op, fl, cnt, 1'b1);
    eb = model(op, fl, cnt, 1'b0);
    @(negedge clk);
    start = 1'b1; opcode = op; flags = fl; count_in = cnt;
    @(negedge clk);
    start = 1'b0; opcode = 8'($urandom); flags = 16'($urandom); count_in = 16'($urandom);
    check("busy_eval", 32'(a_busy), 32'd1);
    check("valid_eval", 32'(a_valid), 32'd0);
    k = 0;
    @(negedge clk);
    while (a_valid !== 1'b1 && k < 4) begin
      k++;
      @(negedge clk);
    end
    check("valid_latency", 32'(k), 32'd0);
    check("a_taken", 32'(a_taken), 32'(ea.taken));
    check("a_illegal", 32'(a_illegal), 32'(ea.illegal));
    check("a_count_out", 32'(a_count_out), 32'(ea.cnt));
    check("a_count_we", 32'(a_count_we), 32'(ea.we));
    check("b_valid", 32'(b_valid), 32'd1);
    check("b_taken", 32'(b_taken), 32'(eb.taken));
    check("b_illegal", 32'(b_illegal), 32'(eb.illegal));
    stats_clear = clr;
    @(negedge clk);
    stats_clear = 1'b0;
    if (clr) begin
      exp_eval_a = 0; exp_taken_a = 0; exp_eval_b = 0; exp_taken_b = 0;
    end else begin
      exp_eval_a = sat_inc(exp_eval_a, 65535);
      exp_eval_b = sat_inc(exp_eval_b, 3);
      if (ea.taken) exp_taken_a = sat_inc(exp_taken_a, 65535);
      if (eb.taken) exp_taken_b = sat_inc(exp_taken_b, 3);
    end
    check("valid_after", 32'(a_valid), 32'd0);
    check("we_after", 32'(a_count_we), 32'd0);
    check("busy_after", 32'(a_busy), 32'd0);
    check("taken_held", 32'(a_taken), 32'(ea.taken));
    check("count_out_held", 32'(a_count_out), 32'(ea.cnt));
    check_counters("stats");
  endtask

  initial begin
    int nv;
    logic [7:0] rop;

    #1;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_taken", 32'(a_taken), 32'd0);
    check("rst_illegal", 32'(a_illegal), 32'd0);
    check("rst_count_out", 32'(a_count_out), 32'd0);
    check("rst_count_we", 32'(a_count_we), 32'd0);
    check_counters("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    do_req(8'h74, 16'h0040, 16'd7, 1'b0);
    do_req(8'h74, 16'h0000, 16'd7, 1'b0);
    do_req(8'hE2, 16'h0000, 16'd1, 1'b0);
    do_req(8'hE2, 16'h0000, 16'd0, 1'b0);
    do_req(8'hE1, 16'h0000, 16'd5, 1'b0);
    do_req(8'hE0, 16'h0040, 16'd5, 1'b0);
    do_req(8'hE3, 16'h0000, 16'd0, 1'b0);
    do_req(8'hE3, 16'h0000, 16'd9, 1'b0);
    do_req(8'h6C, 16'h0080, 16'd0, 1'b0);
    do_req(8'h90, 16'hFFFF, 16'd3, 1'b0);
    do_req(8'h7E, 16'h0880, 16'd3, 1'b0);

    // stats_clear during the valid cycle wins over the increment
    do_req(8'h75, 16'h0000, 16'd0, 1'b1);
    check("clr_zero_a", 32'(a_eval_count), 32'd0);

    // start held high for six edges yields exactly two results
    @(negedge clk);
    start = 1'b1; opcode = 8'h75; flags = 16'h0000; count_in = 16'd0;
    nv = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 5) start = 1'b0;
      if (a_valid === 1'b1) nv++;
    end
    check("held_start_valids", 32'(nv), 32'd2);
    exp_eval_a += 2; exp_taken_a += 2;
    exp_eval_b = sat_inc(sat_inc(exp_eval_b, 3), 3);
    exp_taken_b = sat_inc(sat_inc(exp_taken_b, 3), 3);
    check_counters("held");

    // Reset during EVAL aborts the request
    @(negedge clk);
    start = 1'b1; opcode = 8'hE2; count_in = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check("pre_abort_busy", 32'(a_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    exp_eval_a = 0; exp_taken_a = 0; exp_eval_b = 0; exp_taken_b = 0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_valid", 32'(a_valid), 32'd0);
    check("abort_we", 32'(a_count_we), 32'd0);
    check("abort_count_out", 32'(a_count_out), 32'd0);
    check_counters("abort");
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_valid === 1'b1) nv++;
    end
    check("abort_no_valid", 32'(nv), 32'd0);

    // First start accepted on the first edge after reset release
    reset_n = 1'b1; start = 1'b1; opcode = 8'h74; flags = 16'h0040; count_in = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("first_accept_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("first_valid", 32'(a_valid), 32'd1);
    check("first_taken", 32'(a_taken), 32'd1);
    check("first_we", 32'(a_count_we), 32'd0);
    @(negedge clk);
    exp_eval_a = 1; exp_taken_a = 1; exp_eval_b = 1; exp_taken_b = 1;
    check_counters("first");

    // Saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) do_req(8'hE2, 16'h0000, 16'd5, 1'b0);
    check("sat_b_taken", 32'(b_taken_count), 32'd3);
    check("sat_b_eval", 32'(b_eval_count), 32'd3);
    check("sat_a_eval", 32'(a_eval_count), 32'd6);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rop = {4'h7, 4'($urandom)};
        1:       rop = {4'h6, 4'($urandom)};
        2:       rop = 8'hE0 + 8'($urandom_range(0, 3));
        default: rop = 8'($urandom);
      endcase
      do_req(rop, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom),
             $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
